score_keeper: RTL and testbench
===============================

// Module: score_keeper
// PURPOSE
//  Single-player ping-pong scoring engine, upstream of the 4-digit display driver.
//  - Consumes paddle-hit and ball-miss level signals from the 52-MCU motion-sensor link.
//  - Tracks score, remaining lives and the hit streak.
//  - Drives the 8-bit binary score bus that the display decodes to decimal.
// PARAMETERS
//  LIVES        3         lives granted at game start (1..3, fits lives[1:0])
//  STREAK_LEN   5         consecutive hits that earn a streak bonus (>=2)
//  BONUS        2         extra points added on the STREAK_LEN-th hit
//  HOLD_CYCLES  50000000  clk cycles of post-miss cooldown (1 s at 50 MHz); counter width = $clog2(HOLD_CYCLES+1)
// PORTS
//  clk        in   1  system clock
//  rst        in   1  synchronous, active-high reset
//  start      in   1  1-cycle pulse from the start key path (already debounced, synchronous to clk)
//  hit_in     in   1  MCU level, high = paddle hit; asynchronous to clk
//  miss_in    in   1  MCU level, high = ball missed; asynchronous to clk
//  score      out  8  binary score, 0..255, to display score input
//  lives      out  2  lives remaining
//  game_over  out  1  high while in OVER
//  serving    out  1  high while in SERVE (drives "ready" LED)
// BEHAVIOUR
//  Clocking and reset
//  - One clock domain (clk); rst is synchronous, active-high.
//  - On rst: state=IDLE, score=0, lives=0, streak=0, hold counter=0, all sync flops=0, game_over=0, serving=0.
//  - rst asserted mid-game aborts the game immediately; no partial update lands on that edge.
//  Input conditioning
//  - hit_in and miss_in each pass through 2-flop synchroniser + third flop; event pulse = s2 & ~s3.
//  - Event pulse is exactly 1 cycle per rising edge of the input.
//  - A level held high gives one event only.
//  Latency
//  - Score/lives change at the 3rd rising clk edge after the input is first sampled high.
//  State machine (IDLE, SERVE, RALLY, HOLD, OVER)
//  - IDLE -start-> SERVE: score=0, lives=LIVES, streak=0.
//  - OVER -start-> SERVE: same clears as IDLE -> SERVE.
//  - SERVE -hit-> RALLY: the serving hit is scored.
//  - SERVE/RALLY -miss-> streak=0, lives-=1.
//    - If the new lives value is 0: go to OVER.
//    - Otherwise: go to HOLD and load the hold counter with HOLD_CYCLES.
//  - HOLD: counter decrements every cycle; at 0, go to SERVE.
//    - Hit/miss events arriving in HOLD are discarded, not queued.
//  - OVER: score and lives frozen; only start or rst leave it.
//  - start in SERVE/RALLY/HOLD is ignored.
//  Scoring arithmetic
//  - Each hit: streak+=1. If streak reaches STREAK_LEN, inc=1+BONUS and streak=0; else inc=1.
//  - score = min(score+inc, 255): 9-bit add, saturate at 255, never wrap.
//  - Once saturated, further hits keep score at 255; streak still counts.
//  Simultaneous events
//  - Hit and miss pulses in the same cycle: miss wins, hit dropped.
//  - start and event in the same cycle in IDLE/OVER: start wins, event dropped.
//  Output timing
//  - serving and game_over are registered state decodes, valid the cycle after the transition edge.
// STRUCTURE
//  - Shared package pingpong_pkg holds:
//    - state localparams ST_IDLE..ST_OVER (3-bit);
//    - SCORE_MAX=8'd255;
//    - default LIVES, STREAK_LEN, BONUS, HOLD_CYCLES.
//  - Sub-module edge_sync: 2-flop sync + rising-edge pulse, with clk and rst.
//    - Instantiated twice, for hit_in and miss_in.
//  - Top level holds the FSM, score/lives/streak registers and the hold counter.
// TESTING (bench overrides HOLD_CYCLES=8)
//  - Reset: rst high 2 cycles mid-RALLY with score=7 -> score=0, lives=0, state IDLE, game_over=0.
//  - Streak: start, then 5 separated hit_in pulses -> score 1,2,3,4,7; sixth hit -> 8.
//  - Held level: hit_in held high 20 cycles -> score +1 only, appearing on the 3rd edge after first sample.
//  - Lives/hold: start, hit, miss -> lives=2, serving=0.
//    - Hit during the 8-cycle hold -> score unchanged.
//    - After 8 cycles serving=1.
//    - Three misses total -> game_over=1, lives=0.
//  - Restart: start in OVER -> score=0, lives=3, serving=1; start during RALLY -> no change.
//  - Saturation/collision: preload to 254 via hits, then hit -> 255, further hits -> 255.
//    - Hit and miss rising in the same cycle -> lives-1, score unchanged.

Source files
------------

// File: rtl/pingpong_pkg.sv
// Shared constants and types for the single-player ping-pong scoring engine.
// State encodings, score ceiling, default game parameters and the saturating score add.
package pingpong_pkg;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_SERVE = 3'd1;
   localparam logic [2:0] ST_RALLY = 3'd2;
   localparam logic [2:0] ST_HOLD  = 3'd3;
   localparam logic [2:0] ST_OVER  = 3'd4;

   localparam logic [7:0] SCORE_MAX = 8'd255;

   localparam int LIVES_DEF       = 3;
   localparam int STREAK_LEN_DEF  = 5;
   localparam int BONUS_DEF       = 2;
   localparam int HOLD_CYCLES_DEF = 50_000_000;

   typedef enum logic [2:0] {
      S_IDLE  = ST_IDLE,
      S_SERVE = ST_SERVE,
      S_RALLY = ST_RALLY,
      S_HOLD  = ST_HOLD,
      S_OVER  = ST_OVER
   } state_t;

   // 9-bit add so the carry is visible; clamp instead of wrapping.
   function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [8:0] inc);
      logic [8:0] sum;
      sum = {1'b0, a} + inc;
      if (sum > {1'b0, SCORE_MAX}) return SCORE_MAX;
      else                         return sum[7:0];
   endfunction

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchroniser for an asynchronous level, plus a third flop that turns
// each rising edge of the level into exactly one single-cycle pulse.
module edge_sync (
   input  logic clk,
   input  logic rst,
   input  logic level,
   output logic pulse
);

   logic s1;
   logic s2;
   logic s3;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= level;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign pulse = s2 & ~s3;

endmodule

// File: rtl/score_keeper.sv
// Ping-pong scoring engine: conditions the MCU hit/miss levels, runs the game FSM
// and keeps score, lives, hit streak and the post-miss cooldown counter.
module score_keeper
   import pingpong_pkg::*;
#(
   parameter int LIVES       = LIVES_DEF,
   parameter int STREAK_LEN  = STREAK_LEN_DEF,
   parameter int BONUS       = BONUS_DEF,
   parameter int HOLD_CYCLES = HOLD_CYCLES_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       hit_in,
   input  logic       miss_in,
   output logic [7:0] score,
   output logic [1:0] lives,
   output logic       game_over,
   output logic       serving
);

   localparam int SW = $clog2(STREAK_LEN + 1);
   localparam int HW = $clog2(HOLD_CYCLES + 1);

   logic hit_pulse;
   logic miss_pulse;

   edge_sync u_hit_sync (
      .clk   (clk),
      .rst   (rst),
      .level (hit_in),
      .pulse (hit_pulse)
   );

   edge_sync u_miss_sync (
      .clk   (clk),
      .rst   (rst),
      .level (miss_in),
      .pulse (miss_pulse)
   );

   state_t        state, state_next;
   logic [7:0]    score_next;
   logic [1:0]    lives_next;
   logic [SW-1:0] streak, streak_next, streak_inc;
   logic [HW-1:0] hold_cnt, hold_next;
   logic [8:0]    inc;
   logic          streak_done;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         score     <= 8'd0;
         lives     <= 2'd0;
         streak    <= '0;
         hold_cnt  <= '0;
         serving   <= 1'b0;
         game_over <= 1'b0;
      end else begin
         state     <= state_next;
         score     <= score_next;
         lives     <= lives_next;
         streak    <= streak_next;
         hold_cnt  <= hold_next;
         serving   <= (state_next == S_SERVE);
         game_over <= (state_next == S_OVER);
      end
   end

   always_comb begin
      state_next  = state;
      score_next  = score;
      lives_next  = lives;
      streak_next = streak;
      hold_next   = hold_cnt;
      streak_inc  = streak + 1'b1;
      streak_done = (streak_inc == SW'(STREAK_LEN));
      inc         = streak_done ? 9'(1 + BONUS) : 9'd1;

      case (state)
         S_IDLE, S_OVER: begin
            // start outranks any same-cycle event, which is simply dropped
            if (start) begin
               state_next  = S_SERVE;
               score_next  = 8'd0;
               lives_next  = 2'(LIVES);
               streak_next = '0;
               hold_next   = '0;
            end
         end
         S_SERVE, S_RALLY: begin
            // miss outranks a same-cycle hit
            if (miss_pulse) begin
               streak_next = '0;
               lives_next  = lives - 2'd1;
               if (lives == 2'd1) begin
                  state_next = S_OVER;
               end else begin
                  state_next = S_HOLD;
                  hold_next  = HW'(HOLD_CYCLES);
               end
            end else if (hit_pulse) begin
               state_next  = S_RALLY;
               score_next  = sat_add(score, inc);
               streak_next = streak_done ? '0 : streak_inc;
            end
         end
         S_HOLD: begin
            // leave on the edge where the count reaches zero; events here are discarded
            if (hold_cnt <= HW'(1)) begin
               state_next = S_SERVE;
               hold_next  = '0;
            end else begin
               hold_next = hold_cnt - 1'b1;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper with a short cooldown: a vector table for the
// main game flow plus hand-written sequences for reset, latency, hold timing and saturation.
module tb_score_keeper;

   logic       clk;
   logic       rst;
   logic       start;
   logic       hit_in;
   logic       miss_in;
   logic [7:0] score;
   logic [1:0] lives;
   logic       game_over;
   logic       serving;

   int total = 0;
   int bad   = 0;

   score_keeper #(.HOLD_CYCLES(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .hit_in    (hit_in),
      .miss_in   (miss_in),
      .score     (score),
      .lives     (lives),
      .game_over (game_over),
      .serving   (serving)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       hit;
      logic       miss;
      logic       strt;
      int         settle;
      logic [7:0] score;
      logic [1:0] lives;
      logic       serving;
      logic       over;
   } vec_t;

   vec_t vecs[18];

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input int sc, input int lv, input int sv, input int ov);
      check({tag, ".score"}, int'(score), sc);
      check({tag, ".lives"}, int'(lives), lv);
      check({tag, ".serving"}, int'(serving), sv);
      check({tag, ".game_over"}, int'(game_over), ov);
   endtask

   // inputs are driven for one cycle from a negedge, then the bench waits `settle` more negedges
   task automatic drive(input logic h, input logic m, input logic s, input int settle);
      hit_in  = h;
      miss_in = m;
      start   = s;
      @(negedge clk);
      hit_in  = 1'b0;
      miss_in = 1'b0;
      start   = 1'b0;
      repeat (settle) @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; hit_in = 1'b0; miss_in = 1'b0;
      //          hit   miss  start settle score lives serv over
      vecs[0]  = '{1'b0, 1'b0, 1'b1, 3, 8'd0, 2'd3, 1'b1, 1'b0};  // start from IDLE
      vecs[1]  = '{1'b1, 1'b0, 1'b0, 3, 8'd1, 2'd3, 1'b0, 1'b0};
      vecs[2]  = '{1'b1, 1'b0, 1'b0, 3, 8'd2, 2'd3, 1'b0, 1'b0};
      vecs[3]  = '{1'b1, 1'b0, 1'b0, 3, 8'd3, 2'd3, 1'b0, 1'b0};
      vecs[4]  = '{1'b1, 1'b0, 1'b0, 3, 8'd4, 2'd3, 1'b0, 1'b0};
      vecs[5]  = '{1'b1, 1'b0, 1'b0, 3, 8'd7, 2'd3, 1'b0, 1'b0};  // 5th hit: +1+2
      vecs[6]  = '{1'b1, 1'b0, 1'b0, 3, 8'd8, 2'd3, 1'b0, 1'b0};
      vecs[7]  = '{1'b0, 1'b0, 1'b1, 3, 8'd8, 2'd3, 1'b0, 1'b0};  // start in RALLY ignored
      vecs[8]  = '{1'b0, 1'b1, 1'b0, 3, 8'd8, 2'd2, 1'b0, 1'b0};  // miss -> HOLD
      vecs[9]  = '{1'b1, 1'b0, 1'b0, 3, 8'd8, 2'd2, 1'b0, 1'b0};  // hit in HOLD discarded
      vecs[10] = '{1'b0, 1'b0, 1'b0, 5, 8'd8, 2'd2, 1'b1, 1'b0};  // back to SERVE
      vecs[11] = '{1'b1, 1'b0, 1'b0, 3, 8'd9, 2'd2, 1'b0, 1'b0};
      vecs[12] = '{1'b0, 1'b1, 1'b0, 3, 8'd9, 2'd1, 1'b0, 1'b0};
      vecs[13] = '{1'b0, 1'b0, 1'b0, 10, 8'd9, 2'd1, 1'b1, 1'b0};
      vecs[14] = '{1'b0, 1'b1, 1'b0, 3, 8'd9, 2'd0, 1'b0, 1'b1};  // last life -> OVER
      vecs[15] = '{1'b1, 1'b0, 1'b0, 3, 8'd9, 2'd0, 1'b0, 1'b1};  // frozen in OVER
      vecs[16] = '{1'b0, 1'b0, 1'b1, 3, 8'd0, 2'd3, 1'b1, 1'b0};  // restart from OVER
      vecs[17] = '{1'b0, 1'b1, 1'b0, 3, 8'd0, 2'd2, 1'b0, 1'b0};  // miss straight from SERVE

      // reset state, then abort a rally at score 7
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_all("reset", 0, 0, 0, 0);
      drive(1'b0, 1'b0, 1'b1, 3);
      for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 1'b0, 3);
      check("pre_abort.score", int'(score), 7);
      do_reset();
      check_all("abort", 0, 0, 0, 0);

      // vector table
      for (int i = 0; i < 18; i++) begin
         drive(vecs[i].hit, vecs[i].miss, vecs[i].strt, vecs[i].settle);
         check_all($sformatf("vec%0d", i), int'(vecs[i].score), int'(vecs[i].lives),
                   int'(vecs[i].serving), int'(vecs[i].over));
      end

      // held level: one point, landing on the 3rd edge after the first sample
      do_reset();
      drive(1'b0, 1'b0, 1'b1, 1);
      hit_in = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("held.edge2", int'(score), 0);
      @(negedge clk);
      check("held.edge3", int'(score), 1);
      repeat (17) @(negedge clk);
      hit_in = 1'b0;
      repeat (4) @(negedge clk);
      check("held.end", int'(score), 1);

      // exact cooldown length: 8 cycles in HOLD
      miss_in = 1'b1;
      @(negedge clk);
      miss_in = 1'b0;
      repeat (2) @(negedge clk);
      check("hold.lives", int'(lives), 2);
      check("hold.entry", int'(serving), 0);
      repeat (7) @(negedge clk);
      check("hold.cyc7", int'(serving), 0);
      @(negedge clk);
      check("hold.cyc8", int'(serving), 1);

      // saturation: 36 bonus groups (252) + 2 hits = 254
      do_reset();
      drive(1'b0, 1'b0, 1'b1, 1);
      for (int i = 0; i < 182; i++) drive(1'b1, 1'b0, 1'b0, 3);
      check("sat.254", int'(score), 254);
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b0, 1'b0, 3);
         check($sformatf("sat.255_%0d", i), int'(score), 255);
      end
      drive(1'b1, 1'b1, 1'b0, 3);
      check_all("collide", 255, 2, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
